// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the register-file write port between pipeline writeback and a one-entry
// MDU holding buffer, with starvation-forced stalls and a pending-write scoreboard.
module regfile_wb_scheduler #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    output logic        iss_ready,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        hazard,
    output logic        rf_w_enable,
    output logic [4:0]  rf_w_address,
    output logic [31:0] rf_w_data,
    output logic        err_waw
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    logic          buf_full;
    logic [4:0]    buf_addr;
    logic [31:0]   buf_data;
    logic [WW-1:0] wait_cnt;
    logic [31:0]   pending;
    logic [31:0]   pending_next;

    logic pipe_own;
    logic drain;
    logic accept;
    logic iss_set;

    // Stall and ready come only from registered state so neither source sees a comb loop.
    assign mdu_ready  = !buf_full;
    assign pipe_stall = buf_full && (wait_cnt == WW'(MAX_WAIT));
    assign pipe_own   = pipe_valid && !pipe_stall;
    assign drain      = buf_full && (!pipe_valid || pipe_stall);
    assign accept     = mdu_valid && mdu_ready;

    assign iss_ready  = !pending[iss_addr];
    assign iss_set    = iss_valid && iss_ready && (iss_addr != 5'd0);
    assign hazard     = pending[chk_addr1] | pending[chk_addr2];

    always_comb begin
        rf_w_enable  = 1'b0;
        rf_w_address = 5'd0;
        rf_w_data    = 32'd0;
        if (pipe_own) begin
            rf_w_enable  = (pipe_addr != 5'd0);
            rf_w_address = pipe_addr;
            rf_w_data    = pipe_data;
        end else if (drain) begin
            rf_w_enable  = (buf_addr != 5'd0);
            rf_w_address = buf_addr;
            rf_w_data    = buf_data;
        end
    end

    always_comb begin
        pending_next = pending;
        if (iss_set)
            pending_next[iss_addr] = 1'b1;
        if (drain)
            pending_next[buf_addr] = 1'b0;
        pending_next[0] = 1'b0;
    end

    // Accept and drain are exclusive: accept needs an empty buffer, drain a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            buf_addr <= 5'd0;
            buf_data <= 32'd0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_addr <= mdu_addr;
            buf_data <= mdu_data;
        end else if (drain) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (buf_full && !drain && (wait_cnt != WW'(MAX_WAIT)))
            wait_cnt <= wait_cnt + 1'b1;
        else if (!(buf_full && !drain))
            wait_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 32'd0;
            err_waw <= 1'b0;
        end else begin
            pending <= pending_next;
            if (pipe_own && pending[pipe_addr])
                err_waw <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: reset, MDU latency, starvation stall,
// scoreboard rejection, WAW error and address-0 handling.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        rst_n;
    logic        pipe_valid;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        hazard;
    logic        rf_w_enable;
    logic [4:0]  rf_w_address;
    logic [31:0] rf_w_data;
    logic        err_waw;

    int vectors;
    int miscompares;

    regfile_wb_scheduler #(.MAX_WAIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_valid  (pipe_valid),
        .pipe_addr   (pipe_addr),
        .pipe_data   (pipe_data),
        .pipe_stall  (pipe_stall),
        .mdu_valid   (mdu_valid),
        .mdu_addr    (mdu_addr),
        .mdu_data    (mdu_data),
        .mdu_ready   (mdu_ready),
        .iss_valid   (iss_valid),
        .iss_addr    (iss_addr),
        .iss_ready   (iss_ready),
        .chk_addr1   (chk_addr1),
        .chk_addr2   (chk_addr2),
        .hazard      (hazard),
        .rf_w_enable (rf_w_enable),
        .rf_w_address(rf_w_address),
        .rf_w_data   (rf_w_data),
        .err_waw     (err_waw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                                 input logic mv, input logic [4:0] ma, input logic [31:0] md);
        pipe_valid = pv;
        pipe_addr  = pa;
        pipe_data  = pd;
        mdu_valid  = mv;
        mdu_addr   = ma;
        mdu_data   = md;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        iss_valid   = 1'b0;
        iss_addr    = 5'd0;
        chk_addr1   = 5'd0;
        chk_addr2   = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset state with the pipeline idle
        cycle();
        checkOutput("rst_mdu_ready", 32'(mdu_ready), 32'd1);
        checkOutput("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        checkOutput("rst_hazard", 32'(hazard), 32'd0);
        checkOutput("rst_rf_we", 32'(rf_w_enable), 32'd0);
        checkOutput("rst_err_waw", 32'(err_waw), 32'd0);
        checkOutput("rst_iss_ready", 32'(iss_ready), 32'd1);
        rst_n = 1'b1;
        cycle();

        // Issue r5, then MDU result to r5 with the pipeline idle
        iss_valid = 1'b1;
        iss_addr  = 5'd5;
        #1;
        checkOutput("iss5_ready", 32'(iss_ready), 32'd1);
        cycle();
        iss_valid = 1'b0;
        chk_addr1 = 5'd5;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        checkOutput("hz5_issued", 32'(hazard), 32'd1);
        checkOutput("pre_accept_we", 32'(rf_w_enable), 32'd0);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("n1_mdu_ready", 32'(mdu_ready), 32'd0);
        checkOutput("n1_we", 32'(rf_w_enable), 32'd1);
        checkOutput("n1_addr", 32'(rf_w_address), 32'd5);
        checkOutput("n1_data", rf_w_data, 32'hDEADBEEF);
        checkOutput("n1_hazard", 32'(hazard), 32'd1);
        cycle();
        checkOutput("n2_hazard", 32'(hazard), 32'd0);
        checkOutput("n2_we", 32'(rf_w_enable), 32'd0);
        checkOutput("n2_mdu_ready", 32'(mdu_ready), 32'd1);

        // Scoreboard rejects a second reservation of r7; r0 is always allowed
        iss_valid = 1'b1;
        iss_addr  = 5'd7;
        cycle();
        chk_addr1 = 5'd7;
        #1;
        checkOutput("iss7_busy", 32'(iss_ready), 32'd0);
        checkOutput("hz7", 32'(hazard), 32'd1);
        cycle();
        checkOutput("iss7_still_busy", 32'(iss_ready), 32'd0);
        iss_addr = 5'd0;
        #1;
        checkOutput("iss0_ready", 32'(iss_ready), 32'd1);
        cycle();
        iss_valid = 1'b0;
        chk_addr1 = 5'd0;
        chk_addr2 = 5'd7;
        #1;
        checkOutput("hz7_via_addr2", 32'(hazard), 32'd1);
        chk_addr2 = 5'd0;
        #1;
        checkOutput("hz_r0", 32'(hazard), 32'd0);

        // Starvation: pipeline holds the port for MAX_WAIT cycles, then one forced stall
        applyStimulus(1'b1, 5'd3, 32'h0000_1000, 1'b1, 5'd12, 32'h1234_5678);
        checkOutput("starve_pre_addr", 32'(rf_w_address), 32'd3);
        cycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd3, 32'h0000_1000 + 32'(i), 1'b0, 5'd0, 32'd0);
            checkOutput("starve_no_stall", 32'(pipe_stall), 32'd0);
            checkOutput("starve_pipe_addr", 32'(rf_w_address), 32'd3);
            checkOutput("starve_pipe_data", rf_w_data, 32'h0000_1000 + 32'(i));
            cycle();
        end
        checkOutput("forced_stall", 32'(pipe_stall), 32'd1);
        checkOutput("forced_we", 32'(rf_w_enable), 32'd1);
        checkOutput("forced_addr", 32'(rf_w_address), 32'd12);
        checkOutput("forced_data", rf_w_data, 32'h1234_5678);
        cycle();
        checkOutput("post_stall", 32'(pipe_stall), 32'd0);
        checkOutput("post_mdu_ready", 32'(mdu_ready), 32'd1);
        checkOutput("post_pipe_data", rf_w_data, 32'h0000_1003);
        applyStimulus(1'b1, 5'd3, 32'h0000_2000, 1'b1, 5'd13, 32'h0BAD_F00D);
        cycle();
        applyStimulus(1'b1, 5'd3, 32'h0000_2001, 1'b0, 5'd0, 32'd0);
        checkOutput("restart_no_stall", 32'(pipe_stall), 32'd0);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("idle_drain_addr", 32'(rf_w_address), 32'd13);
        cycle();

        // Pipeline write to a register with a pending MDU write raises sticky err_waw
        iss_valid = 1'b1;
        iss_addr  = 5'd9;
        cycle();
        iss_valid = 1'b0;
        applyStimulus(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'd0);
        checkOutput("waw_before", 32'(err_waw), 32'd0);
        checkOutput("waw_we", 32'(rf_w_enable), 32'd1);
        checkOutput("waw_addr", 32'(rf_w_address), 32'd9);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("waw_set", 32'(err_waw), 32'd1);
        cycle();
        cycle();
        checkOutput("waw_sticky", 32'(err_waw), 32'd1);

        // Address 0 from MDU and pipe: consumed without a write
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("r0_mdu_full", 32'(mdu_ready), 32'd0);
        checkOutput("r0_mdu_we", 32'(rf_w_enable), 32'd0);
        cycle();
        checkOutput("r0_mdu_drained", 32'(mdu_ready), 32'd1);
        applyStimulus(1'b1, 5'd0, 32'h5555_5555, 1'b0, 5'd0, 32'd0);
        checkOutput("r0_pipe_we", 32'(rf_w_enable), 32'd0);

        // Mid-operation reset with a full buffer and live reservations
        iss_valid = 1'b1;
        iss_addr  = 5'd20;
        applyStimulus(1'b1, 5'd1, 32'h0000_0001, 1'b0, 5'd0, 32'd0);
        cycle();
        iss_valid = 1'b0;
        applyStimulus(1'b1, 5'd1, 32'h0000_0002, 1'b1, 5'd20, 32'hCAFE_0020);
        cycle();
        applyStimulus(1'b1, 5'd1, 32'h0000_0003, 1'b0, 5'd0, 32'd0);
        chk_addr1 = 5'd20;
        chk_addr2 = 5'd7;
        #1;
        checkOutput("prerst_full", 32'(mdu_ready), 32'd0);
        checkOutput("prerst_hazard", 32'(hazard), 32'd1);
        pipe_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        checkOutput("midrst_we", 32'(rf_w_enable), 32'd0);
        checkOutput("midrst_mdu_ready", 32'(mdu_ready), 32'd1);
        checkOutput("midrst_hazard", 32'(hazard), 32'd0);
        checkOutput("midrst_err_waw", 32'(err_waw), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        iss_addr = 5'd7;
        #1;
        checkOutput("postrst_we", 32'(rf_w_enable), 32'd0);
        checkOutput("postrst_iss7", 32'(iss_ready), 32'd1);
        checkOutput("postrst_stall", 32'(pipe_stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
